// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared types and helpers for the LED driver channels.
//             - led_state_t : per-channel FSM state (IDLE / ON / GAP)
//             - cnt_width() : width of a down-counter that can hold
//                             max(a, b) without overflow
//  Revision : 1.0  initial release
// ============================================================================
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } led_state_t;

  // Smallest width able to represent every value 0..max(a, b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
//  Module   : led_channel
//  Purpose  : One LED channel. A one-cycle trig lights the LED for
//             HOLD_CYCLES cycles, then forces a GAP_CYCLES dark gap.
//             A trig during ON retriggers; a trig during GAP is held as a
//             single pending request. clr extinguishes (and beats trig).
//             Unhit timeouts raise a one-cycle expired pulse.
//  Ports    : clk     - system clock (posedge)
//             rst     - asynchronous active-high reset
//             trig    - one-cycle light request
//             clr     - one-cycle extinguish request (hit)
//             led     - registered LED drive
//             busy    - channel not idle or has a pending trigger
//             expired - registered one-cycle timeout pulse
//  Macro    : LED_BLINK_EN - blink the LED with half-period BLINK_HALF
//             while ON; otherwise the LED is steady during ON.
//  Revision : 1.0  initial release
// ============================================================================
module led_channel
  import led_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int BLINK_HALF  = 6250000
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic clr,
  output logic led,
  output logic busy,
  output logic expired
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
  // With no gap configured, leaving ON goes straight to IDLE with cnt=0.
  localparam logic [CNT_W-1:0] c_after_on_cnt =
      (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam led_state_t c_after_on_state = (GAP_CYCLES > 0) ? GAP : IDLE;

  led_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_led;
  logic             r_expired;

  // clr beats trig in every state.
  logic w_trig;
  logic w_cnt_zero;
  logic w_load_on;   // entering ON or reloading it this cycle
  logic w_stay_on;   // remaining in ON without a reload

  assign w_trig     = trig & ~clr;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_load_on  = (w_trig & ((r_state == IDLE) | (r_state == ON))) |
                      ((r_state == GAP) & w_cnt_zero & (r_pending | trig) & ~clr);
  assign w_stay_on  = (r_state == ON) & ~clr & ~w_cnt_zero;

`ifdef LED_BLINK_EN
  localparam int PH_W = cnt_width(BLINK_HALF, 0);
  localparam logic [PH_W-1:0] c_phase_last = PH_W'(BLINK_HALF - 1);
  logic [PH_W-1:0] r_phase;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_led     <= 1'b0;
      r_expired <= 1'b0;
`ifdef LED_BLINK_EN
      r_phase   <= '0;
`endif
    end else begin
      r_expired <= 1'b0;

      unique case (r_state)
        IDLE: begin
          r_pending <= 1'b0;
          if (w_trig) begin
            r_state <= ON;
            r_cnt   <= c_hold_load;
          end
        end

        ON: begin
          r_pending <= 1'b0;
          if (clr) begin
            r_state <= c_after_on_state;
            r_cnt   <= c_after_on_cnt;
          end else if (trig) begin
            r_cnt <= c_hold_load;
          end else if (w_cnt_zero) begin
            r_state   <= c_after_on_state;
            r_cnt     <= c_after_on_cnt;
            r_expired <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (w_cnt_zero) begin
            // A trig arriving in the final gap cycle counts as pending.
            r_pending <= 1'b0;
            if ((r_pending | trig) & ~clr) begin
              r_state <= ON;
              r_cnt   <= c_hold_load;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt     <= r_cnt - CNT_W'(1);
            r_pending <= clr ? 1'b0 : (r_pending | trig);
          end
        end

        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_pending <= 1'b0;
        end
      endcase

`ifdef LED_BLINK_EN
      // Phase restarts high on every (re)load; dark outside ON.
      if (w_load_on) begin
        r_led   <= 1'b1;
        r_phase <= '0;
      end else if (w_stay_on) begin
        if (r_phase == c_phase_last) begin
          r_phase <= '0;
          r_led   <= ~r_led;
        end else begin
          r_phase <= r_phase + PH_W'(1);
        end
      end else begin
        r_led   <= 1'b0;
        r_phase <= '0;
      end
`else
      r_led <= w_load_on | w_stay_on;
`endif
    end
  end

  assign led     = r_led;
  assign expired = r_expired;
  assign busy    = (r_state != IDLE) | r_pending;

endmodule
`default_nettype wire

// File: rtl/led_driver.sv
`default_nettype none
// ============================================================================
//  Module   : led_driver
//  Purpose  : N_LEDS independent timed LED channels between the game FSM
//             and the LED pins. Each channel turns trig/clr pulses into a
//             timed LED level with a minimum dark gap and reports unhit
//             timeouts on expired.
//  Ports    : clk     - system clock (posedge)
//             rst     - asynchronous active-high reset
//             trig    - [N_LEDS] one-cycle light requests
//             clr     - [N_LEDS] one-cycle extinguish requests
//             led     - [N_LEDS] registered LED drive
//             busy    - [N_LEDS] channel active or pending
//             expired - [N_LEDS] one-cycle timeout pulses
//  Macro    : LED_BLINK_EN - enables blinking while ON (see led_channel)
//  Revision : 1.0  initial release
// ============================================================================
module led_driver
  import led_pkg::*;
#(
  parameter int N_LEDS      = 8,
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int BLINK_HALF  = 6250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] trig,
  input  logic [N_LEDS-1:0] clr,
  output logic [N_LEDS-1:0] led,
  output logic [N_LEDS-1:0] busy,
  output logic [N_LEDS-1:0] expired
);

  genvar gi;
  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_ch
      led_channel #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .BLINK_HALF  (BLINK_HALF)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig[gi]),
        .clr     (clr[gi]),
        .led     (led[gi]),
        .busy    (busy[gi]),
        .expired (expired[gi])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_driver
//  Purpose  : Self-checking bench for led_driver (N_LEDS=2, HOLD=4, GAP=2,
//             BLINK_HALF=2). Expected per-cycle outputs are pushed to a
//             scoreboard queue as stimulus is driven and popped on compare.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_driver;

  localparam int N_LEDS      = 2;
  localparam int HOLD_CYCLES = 4;
  localparam int GAP_CYCLES  = 2;
  localparam int BLINK_HALF  = 2;

  typedef struct packed {
    logic [1:0] led;
    logic [1:0] busy;
    logic [1:0] exp;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] trig = '0;
  logic [1:0] clr = '0;
  logic [1:0] led, busy, expired;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  led_driver #(
    .N_LEDS      (N_LEDS),
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .BLINK_HALF  (BLINK_HALF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .clr     (clr),
    .led     (led),
    .busy    (busy),
    .expired (expired)
  );

  // Present inputs for one cycle, then land 1 time unit after the edge.
  task automatic drive_step(input logic [1:0] t, input logic [1:0] c);
    trig = t;
    clr  = c;
    @(posedge clk);
    #1;
    trig = '0;
    clr  = '0;
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got = {led, busy, expired};
    n_tests++;
    if (got !== '0)
      begin n_fail++; $display("FAIL reset: got %b want %b", got, 6'b0); end
    rst = 1'b0;
    drive_step(2'b00, 2'b00);
  endtask

  task automatic test_basic();
    logic [1:0] tg [8] = '{2'b01, 0, 0, 0, 0, 0, 0, 0};
`ifdef LED_BLINK_EN
    logic [1:0] el [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
`else
    logic [1:0] el [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
    logic [1:0] eb [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0] ee [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    obs_t got, want;
    for (int i = 0; i < 8; i++) begin
      sb.push_back({el[i], eb[i], ee[i]});
      drive_step(tg[i], 2'b00);
      got = {led, busy, expired};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic cyc t+%0d: got led=%b busy=%b exp=%b want led=%b busy=%b exp=%b",
                 i + 1, got.led, got.busy, got.exp, want.led, want.busy, want.exp);
      end
    end
  endtask

  task automatic test_all_channels();
    obs_t got, want;
    for (int i = 0; i < 8; i++) begin
`ifdef LED_BLINK_EN
      sb.push_back({(i < 2) ? 2'b11 : 2'b00, (i < 6) ? 2'b11 : 2'b00, (i == 4) ? 2'b11 : 2'b00});
`else
      sb.push_back({(i < 4) ? 2'b11 : 2'b00, (i < 6) ? 2'b11 : 2'b00, (i == 4) ? 2'b11 : 2'b00});
`endif
      drive_step((i == 0) ? 2'b11 : 2'b00, 2'b00);
      got = {led, busy, expired};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL all_ch cyc t+%0d: got led=%b busy=%b exp=%b want led=%b busy=%b exp=%b",
                 i + 1, got.led, got.busy, got.exp, want.led, want.busy, want.exp);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [1:0] tg [10] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
`ifdef LED_BLINK_EN
    logic [1:0] el [10] = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
`else
    logic [1:0] el [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
`endif
    logic [1:0] eb [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [1:0] ee [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    obs_t got, want;
    for (int i = 0; i < 10; i++) begin
      sb.push_back({el[i], eb[i], ee[i]});
      drive_step(tg[i], 2'b00);
      got = {led, busy, expired};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL retrig cyc t+%0d: got led=%b busy=%b exp=%b want led=%b busy=%b exp=%b",
                 i + 1, got.led, got.busy, got.exp, want.led, want.busy, want.exp);
      end
    end
  endtask

  task automatic test_pending();
    // Two trigs in the gap (t+5, t+6) collapse into one relaunch.
    logic [1:0] tg [14] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
`ifdef LED_BLINK_EN
    logic [1:0] el [14] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
`else
    logic [1:0] el [14] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`endif
    logic [1:0] eb [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0] ee [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    obs_t got, want;
    for (int i = 0; i < 14; i++) begin
      sb.push_back({el[i], eb[i], ee[i]});
      drive_step(tg[i], 2'b00);
      got = {led, busy, expired};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL pending cyc t+%0d: got led=%b busy=%b exp=%b want led=%b busy=%b exp=%b",
                 i + 1, got.led, got.busy, got.exp, want.led, want.busy, want.exp);
      end
    end
  endtask

  task automatic test_clear();
    // trig[1] at t, clr[1] at t+2: dark from t+3, no expired, idle at t+5.
    logic [1:0] tg [6] = '{2'b10, 0, 0, 0, 0, 0};
    logic [1:0] cl [6] = '{0, 0, 2'b10, 0, 0, 0};
    logic [1:0] el [6] = '{2'b10, 2'b10, 0, 0, 0, 0};
    logic [1:0] eb [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 0, 0};
    obs_t got, want;
    for (int i = 0; i < 6; i++) begin
      sb.push_back({el[i], eb[i], 2'b00});
      drive_step(tg[i], cl[i]);
      got = {led, busy, expired};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL clear cyc t+%0d: got led=%b busy=%b exp=%b want led=%b busy=%b exp=%b",
                 i + 1, got.led, got.busy, got.exp, want.led, want.busy, want.exp);
      end
    end
    // trig and clr together in IDLE: nothing happens.
    for (int i = 0; i < 3; i++) begin
      sb.push_back('0);
      drive_step((i == 0) ? 2'b01 : 2'b00, (i == 0) ? 2'b01 : 2'b00);
      got = {led, busy, expired};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL clr_prio cyc t+%0d: got %b want %b", i + 1, got, want);
      end
    end
  endtask

  task automatic test_gap_clear();
    // Pending set at t+5, cleared by clr at t+6: no relaunch.
    logic [1:0] tg [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
    logic [1:0] cl [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic [1:0] eb [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [1:0] ee [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    obs_t got, want;
    for (int i = 0; i < 8; i++) begin
`ifdef LED_BLINK_EN
      sb.push_back({(i < 2) ? 2'b01 : 2'b00, eb[i], ee[i]});
`else
      sb.push_back({(i < 4) ? 2'b01 : 2'b00, eb[i], ee[i]});
`endif
      drive_step(tg[i], cl[i]);
      got = {led, busy, expired};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL gap_clr cyc t+%0d: got led=%b busy=%b exp=%b want led=%b busy=%b exp=%b",
                 i + 1, got.led, got.busy, got.exp, want.led, want.busy, want.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got;
    // Mid-ON reset between edges.
    drive_step(2'b01, 2'b00);
    drive_step(2'b00, 2'b00);
    #3 rst = 1'b1;
    #1;
    got = {led, busy, expired};
    n_tests++;
    if (got !== '0)
      begin n_fail++; $display("FAIL async_rst_on: got %b want %b", got, 6'b0); end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    // Reset during the expired cycle drops the pulse.
    for (int i = 0; i < 5; i++) drive_step((i == 0) ? 2'b01 : 2'b00, 2'b00);
    n_tests++;
    if (expired !== 2'b01)
      begin n_fail++; $display("FAIL pre_rst_expired: got %b want %b", expired, 2'b01); end
    #2 rst = 1'b1;
    #1;
    got = {led, busy, expired};
    n_tests++;
    if (got !== '0)
      begin n_fail++; $display("FAIL async_rst_exp: got %b want %b", got, 6'b0); end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    // Channel must accept a fresh trig after release.
    sb.push_back({2'b01, 2'b01, 2'b00});
    drive_step(2'b01, 2'b00);
    got = {led, busy, expired};
    n_tests++;
    begin
      obs_t want;
      want = sb.pop_front();
      if (got !== want)
        begin n_fail++; $display("FAIL post_rst_trig: got %b want %b", got, want); end
    end
    repeat (8) drive_step(2'b00, 2'b00);
    got = {led, busy, expired};
    n_tests++;
    if (got !== '0)
      begin n_fail++; $display("FAIL post_rst_idle: got %b want %b", got, 6'b0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_channels();
    test_retrigger();
    test_pending();
    test_clear();
    test_gap_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
